// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter
//
// Shares one memory read channel between the I-cache refill path
// (requester 0) and the D-cache refill path (requester 1). One requester
// is granted at a time, round-robin on ties, and the grant is held for the
// whole burst until the beat marked last has been accepted.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   from_ic_rd_req_*         I-cache request (valid, addr) / to_ic_rd_req_ready
//   to_ic_rd_rsp_*           beats to I-cache (valid, data, last) / from_ic_rd_rsp_ready
//   from_dc_rd_req_*         D-cache request, same shape as the I-cache set
//   to_dc_rd_rsp_*           beats to D-cache, same shape as the I-cache set
//   to_mem_rd_req_*          memory request (valid, latched addr) / from_mem_rd_req_ready
//   from_mem_rd_rsp_*        memory beats (valid, data, last) / to_mem_rd_rsp_ready
//   grant_id                 owner of the current burst (0 = I, 1 = D)
//   burst_err                sticky: a burst ended with a beat count != BURST_LEN

module mem_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache
  input  logic                  from_ic_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_ic_rd_req_addr,
  output logic                  to_ic_rd_req_ready,
  output logic                  to_ic_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_ic_rd_rsp_data,
  output logic                  to_ic_rd_rsp_last,
  input  logic                  from_ic_rd_rsp_ready,
  // D-cache
  input  logic                  from_dc_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_dc_rd_req_addr,
  output logic                  to_dc_rd_req_ready,
  output logic                  to_dc_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_dc_rd_rsp_data,
  output logic                  to_dc_rd_rsp_last,
  input  logic                  from_dc_rd_rsp_ready,
  // memory
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready,
  // status
  output logic                  grant_id,
  output logic                  burst_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    s_IDLE,
    s_REQ,
    s_RSP
  } state_t;

  state_t                state_q, state_d;
  logic                  grant_id_q, grant_id_d;
  logic                  rr_last_q, rr_last_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  burst_err_q, burst_err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  win_id;
  logic                  gnt_rsp_ready;
  logic                  beat_xfer;
  logic [CNT_W:0]        cnt_plus_one;

  // On a tie the requester that did not own the previous burst wins, so a
  // waiting requester can never be starved by a continuously requesting one.
  assign win_id = (from_ic_rd_req_valid && from_dc_rd_req_valid) ? ~rr_last_q
                                                                 : from_dc_rd_req_valid;

  assign gnt_rsp_ready = grant_id_q ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
  assign beat_xfer     = (state_q == s_RSP) && from_mem_rd_rsp_valid && gnt_rsp_ready;
  // One bit wider than the counter so a saturated count still compares as
  // "too many beats" when last finally arrives.
  assign cnt_plus_one  = {1'b0, beat_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= s_IDLE;
      grant_id_q  <= 1'b0;
      rr_last_q   <= 1'b1;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_last_q   <= rr_last_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
      addr_q      <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_last_d   = rr_last_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    addr_d      = addr_q;

    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_rsp_ready = 1'b0;

    unique case (state_q)
      s_IDLE: begin
        // Ready is masked while rst is high so no handshake is offered
        // during reset, even though the state flops already read idle.
        if ((from_ic_rd_req_valid || from_dc_rd_req_valid) && !rst) begin
          to_ic_rd_req_ready = ~win_id;
          to_dc_rd_req_ready = win_id;
          addr_d     = win_id ? from_dc_rd_req_addr : from_ic_rd_req_addr;
          grant_id_d = win_id;
          beat_cnt_d = '0;
          state_d    = s_REQ;
        end
      end

      s_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) begin
          state_d = s_RSP;
        end
      end

      s_RSP: begin
        to_mem_rd_rsp_ready = gnt_rsp_ready;
        if (grant_id_q) begin
          to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
        end

        if (beat_xfer) begin
          if (beat_cnt_q != BURST_MAX) begin
            beat_cnt_d = cnt_plus_one[CNT_W-1:0];
          end
          if (from_mem_rd_rsp_last) begin
            if (cnt_plus_one != {1'b0, BURST_MAX}) begin
              burst_err_d = 1'b1;
            end
            rr_last_d = grant_id_q;
            state_d   = s_IDLE;
          end
        end
      end

      default: begin
        state_d = s_IDLE;
      end
    endcase
  end

  assign to_mem_rd_req_addr = addr_q;
  assign grant_id           = grant_id_q;
  assign burst_err          = burst_err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed testbench for mem_rd_arbiter: a small memory responder and
// requester drivers, with each scenario task checking its own results.
module tb_mem_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        from_ic_rd_req_valid;
  logic [31:0] from_ic_rd_req_addr;
  logic        to_ic_rd_req_ready;
  logic        to_ic_rd_rsp_valid;
  logic [31:0] to_ic_rd_rsp_data;
  logic        to_ic_rd_rsp_last;
  logic        from_ic_rd_rsp_ready;
  logic        from_dc_rd_req_valid;
  logic [31:0] from_dc_rd_req_addr;
  logic        to_dc_rd_req_ready;
  logic        to_dc_rd_rsp_valid;
  logic [31:0] to_dc_rd_rsp_data;
  logic        to_dc_rd_rsp_last;
  logic        from_dc_rd_rsp_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;
  logic        grant_id;
  logic        burst_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [32:0] ic_beats[$];
  logic [32:0] dc_beats[$];
  logic [31:0] addr_log[$];
  logic        gid_log[$];
  int          ic_last_cyc;
  int          dc_acc_cyc;
  bit          dc_rsp_seen;

  mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .from_ic_rd_req_valid (from_ic_rd_req_valid),
    .from_ic_rd_req_addr  (from_ic_rd_req_addr),
    .to_ic_rd_req_ready   (to_ic_rd_req_ready),
    .to_ic_rd_rsp_valid   (to_ic_rd_rsp_valid),
    .to_ic_rd_rsp_data    (to_ic_rd_rsp_data),
    .to_ic_rd_rsp_last    (to_ic_rd_rsp_last),
    .from_ic_rd_rsp_ready (from_ic_rd_rsp_ready),
    .from_dc_rd_req_valid (from_dc_rd_req_valid),
    .from_dc_rd_req_addr  (from_dc_rd_req_addr),
    .to_dc_rd_req_ready   (to_dc_rd_req_ready),
    .to_dc_rd_rsp_valid   (to_dc_rd_rsp_valid),
    .to_dc_rd_rsp_data    (to_dc_rd_rsp_data),
    .to_dc_rd_rsp_last    (to_dc_rd_rsp_last),
    .from_dc_rd_rsp_ready (from_dc_rd_rsp_ready),
    .to_mem_rd_req_valid  (to_mem_rd_req_valid),
    .to_mem_rd_req_addr   (to_mem_rd_req_addr),
    .from_mem_rd_req_ready(from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data (from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last (from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready  (to_mem_rd_rsp_ready),
    .grant_id             (grant_id),
    .burst_err            (burst_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat delivered to either cache and key handshake cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (to_ic_rd_rsp_valid && from_ic_rd_rsp_ready) begin
        ic_beats.push_back({to_ic_rd_rsp_last, to_ic_rd_rsp_data});
        if (to_ic_rd_rsp_last) ic_last_cyc = cyc;
      end
      if (to_dc_rd_rsp_valid && from_dc_rd_rsp_ready) begin
        dc_beats.push_back({to_dc_rd_rsp_last, to_dc_rd_rsp_data});
      end
      if (to_dc_rd_rsp_valid) dc_rsp_seen = 1'b1;
      if (from_dc_rd_req_valid && to_dc_rd_req_ready) dc_acc_cyc = cyc;
    end
  end

  task automatic clear_logs();
    ic_beats.delete();
    dc_beats.delete();
    addr_log.delete();
    gid_log.delete();
    dc_rsp_seen = 1'b0;
    ic_last_cyc = -100;
    dc_acc_cyc  = -200;
  endtask

  // Requester driver: hold valid until n grants were taken, then drop it.
  task automatic issue(input bit id, input logic [31:0] addr, input int n);
    int cnt;
    int t;
    cnt = 0;
    t   = 0;
    if (id) begin
      from_dc_rd_req_valid = 1'b1;
      from_dc_rd_req_addr  = addr;
    end else begin
      from_ic_rd_req_valid = 1'b1;
      from_ic_rd_req_addr  = addr;
    end
    while (cnt < n && t < 400) begin
      @(negedge clk);
      t++;
      if (id ? (to_dc_rd_req_ready === 1'b1) : (to_ic_rd_req_ready === 1'b1)) cnt++;
    end
    @(posedge clk);
    #1;
    if (id) from_dc_rd_req_valid = 1'b0;
    else    from_ic_rd_req_valid = 1'b0;
    if (cnt < n) begin
      total++;
      bad++;
      $display("FAIL issue_timeout id=%0d grants=%0d required=%0d", id, cnt, n);
    end
  endtask

  // Memory responder: accept one request after 'delay' cycles, then return
  // nbeats beats base, base+1, ... with last on the final one.
  task automatic serve(input int nbeats, input logic [31:0] base, input int delay);
    int t;
    @(negedge clk);
    t = 0;
    while (to_mem_rd_req_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      total++;
      bad++;
      $display("FAIL serve_req_timeout got=no_request required=request");
      return;
    end
    addr_log.push_back(to_mem_rd_req_addr);
    gid_log.push_back(grant_id);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    from_mem_rd_req_ready = 1'b1;
    @(posedge clk);
    #1;
    from_mem_rd_req_ready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = base + 32'(b);
      from_mem_rd_rsp_last  = (b == nbeats - 1);
      t = 0;
      @(negedge clk);
      while (to_mem_rd_rsp_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        total++;
        bad++;
        $display("FAIL serve_beat_timeout beat=%0d got=no_ready required=ready", b);
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({to_ic_rd_req_ready, to_dc_rd_req_ready, to_ic_rd_rsp_valid, to_dc_rd_rsp_valid,
         to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_handshakes got=%b required=000000",
               {to_ic_rd_req_ready, to_dc_rd_req_ready, to_ic_rd_rsp_valid,
                to_dc_rd_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready});
    end
    total++;
    if ({grant_id, burst_err} !== 2'b00 || to_mem_rd_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got=gid%b err%b addr%h required=gid0 err0 addr0",
               grant_id, burst_err, to_mem_rd_req_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_req_ready} !== 3'b0) begin
      bad++;
      $display("FAIL after_reset_handshakes got=%b required=000",
               {to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_req_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_ic();
    clear_logs();
    fork
      issue(1'b0, 32'h0000_1000, 1);
      serve(8, 32'h0, 2);
    join
    total++;
    if (addr_log[0] !== 32'h0000_1000 || gid_log[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_req got=addr%h gid%b required=addr00001000 gid0", addr_log[0], gid_log[0]);
    end
    total++;
    if (ic_beats.size() != 8) begin
      bad++;
      $display("FAIL single_count got=%0d required=8", ic_beats.size());
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ic_beats[i] !== {(i == 7), 32'(i)}) begin
        bad++;
        $display("FAIL single_beat%0d got=%h required=%h", i, ic_beats[i], {(i == 7), 32'(i)});
      end
    end
    total++;
    if (dc_rsp_seen !== 1'b0 || burst_err !== 1'b0) begin
      bad++;
      $display("FAIL single_side got=dc_seen%b err%b required=dc_seen0 err0", dc_rsp_seen, burst_err);
    end
    @(negedge clk);
    total++;
    if ({to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_rsp_valid} !== 3'b0) begin
      bad++;
      $display("FAIL single_idle got=%b required=000",
               {to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_rsp_valid});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    clear_logs();
    fork
      issue(1'b0, 32'h100, 1);
      issue(1'b1, 32'h200, 1);
      begin
        serve(8, 32'h10, 0);
        serve(8, 32'h20, 1);
      end
    join
    total++;
    if (gid_log[0] !== 1'b0 || gid_log[1] !== 1'b1) begin
      bad++;
      $display("FAIL tie_order got=%b%b required=01", gid_log[0], gid_log[1]);
    end
    total++;
    if (addr_log[0] !== 32'h100 || addr_log[1] !== 32'h200) begin
      bad++;
      $display("FAIL tie_addr got=%h,%h required=00000100,00000200", addr_log[0], addr_log[1]);
    end
    total++;
    if (dc_acc_cyc != ic_last_cyc + 1) begin
      bad++;
      $display("FAIL tie_gap got=%0d required=%0d", dc_acc_cyc, ic_last_cyc + 1);
    end
    total++;
    if (ic_beats.size() != 8 || dc_beats.size() != 8 ||
        ic_beats[7] !== {1'b1, 32'h17} || dc_beats[0] !== {1'b0, 32'h20}) begin
      bad++;
      $display("FAIL tie_data got=ic%0d/%h dc%0d/%h required=8/100000017 8/020",
               ic_beats.size(), ic_beats[7], dc_beats.size(), dc_beats[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    fork
      issue(1'b0, 32'hA00, 2);
      issue(1'b1, 32'hB00, 2);
      repeat (4) serve(8, 32'h30, 0);
    join
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gid_log[i] !== 1'(i % 2) || addr_log[i] !== ((i % 2) ? 32'hB00 : 32'hA00)) begin
        bad++;
        $display("FAIL b2b_grant%0d got=gid%b addr%h required=gid%0d addr%h", i, gid_log[i],
                 addr_log[i], i % 2, (i % 2) ? 32'hB00 : 32'hA00);
      end
    end
  endtask

  task automatic test_rsp_stall();
    int t;
    clear_logs();
    fork
      issue(1'b0, 32'hC00, 1);
      serve(8, 32'h40, 1);
      begin
        t = 0;
        while (ic_beats.size() < 3 && t < 200) begin
          @(posedge clk);
          #1;
          t++;
        end
        from_ic_rd_rsp_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          total++;
          if (to_mem_rd_rsp_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready got=%b required=0", to_mem_rd_rsp_ready);
          end
        end
        @(posedge clk);
        #1;
        from_ic_rd_rsp_ready = 1'b1;
      end
    join
    total++;
    if (ic_beats.size() != 8) begin
      bad++;
      $display("FAIL stall_count got=%0d required=8", ic_beats.size());
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ic_beats[i] !== {(i == 7), 32'h40 + 32'(i)}) begin
        bad++;
        $display("FAIL stall_beat%0d got=%h required=%h", i, ic_beats[i], {(i == 7), 32'h40 + 32'(i)});
      end
    end
    total++;
    if (burst_err !== 1'b0) begin
      bad++;
      $display("FAIL stall_err got=%b required=0", burst_err);
    end
  endtask

  task automatic test_short_burst();
    clear_logs();
    fork
      issue(1'b0, 32'hD00, 1);
      serve(6, 32'h50, 0);
    join
    total++;
    if (burst_err !== 1'b1 || ic_beats.size() != 6 || ic_beats[5] !== {1'b1, 32'h55}) begin
      bad++;
      $display("FAIL short_err got=err%b n%0d last%h required=err1 n6 last100000055",
               burst_err, ic_beats.size(), ic_beats[5]);
    end
    clear_logs();
    fork
      issue(1'b1, 32'hE00, 1);
      serve(8, 32'h60, 0);
    join
    total++;
    if (burst_err !== 1'b1 || gid_log[0] !== 1'b1 || dc_beats.size() != 8) begin
      bad++;
      $display("FAIL short_sticky got=err%b gid%b n%0d required=err1 gid1 n8",
               burst_err, gid_log[0], dc_beats.size());
    end
  endtask

  task automatic test_async_reset();
    from_mem_rd_req_ready = 1'b1;
    from_ic_rd_req_valid  = 1'b1;
    from_ic_rd_req_addr   = 32'h3000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    from_mem_rd_req_ready = 1'b0;
    from_mem_rd_rsp_valid = 1'b1;
    from_mem_rd_rsp_data  = 32'hAA;
    from_mem_rd_rsp_last  = 1'b0;
    @(negedge clk);
    total++;
    if (to_ic_rd_rsp_valid !== 1'b1 || to_ic_rd_rsp_data !== 32'hAA) begin
      bad++;
      $display("FAIL areset_pre got=v%b d%h required=v1 d000000aa", to_ic_rd_rsp_valid, to_ic_rd_rsp_data);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready,
         burst_err, grant_id} !== 6'b0) begin
      bad++;
      $display("FAIL areset_outputs got=%b required=000000",
               {to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_mem_rd_req_valid,
                to_mem_rd_rsp_ready, burst_err, grant_id});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    from_ic_rd_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (to_mem_rd_rsp_ready !== 1'b0 || to_ic_rd_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_mem_beat got=rdy%b v%b required=rdy0 v0", to_mem_rd_rsp_ready, to_ic_rd_rsp_valid);
    end
    @(posedge clk);
    #1;
    from_mem_rd_rsp_valid = 1'b0;
    clear_logs();
    fork
      issue(1'b1, 32'hF00, 1);
      serve(8, 32'h70, 0);
    join
    total++;
    if (gid_log[0] !== 1'b1 || addr_log[0] !== 32'hF00 || dc_beats.size() != 8 ||
        dc_beats[7] !== {1'b1, 32'h77} || burst_err !== 1'b0) begin
      bad++;
      $display("FAIL areset_fresh got=gid%b addr%h n%0d last%h err%b required=gid1 addr00000f00 n8 last100000077 err0",
               gid_log[0], addr_log[0], dc_beats.size(), dc_beats[7], burst_err);
    end
  endtask

  initial begin
    rst                   = 1'b1;
    from_ic_rd_req_valid  = 1'b0;
    from_ic_rd_req_addr   = 32'h0;
    from_ic_rd_rsp_ready  = 1'b1;
    from_dc_rd_req_valid  = 1'b0;
    from_dc_rd_req_addr   = 32'h0;
    from_dc_rd_rsp_ready  = 1'b1;
    from_mem_rd_req_ready = 1'b0;
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_data  = 32'h0;
    from_mem_rd_rsp_last  = 1'b0;
    clear_logs();

    test_reset();
    $display("test_reset done total=%0d bad=%0d", total, bad);
    test_single_ic();
    $display("test_single_ic done total=%0d bad=%0d", total, bad);
    test_tie_after_reset();
    $display("test_tie_after_reset done total=%0d bad=%0d", total, bad);
    test_back_to_back();
    $display("test_back_to_back done total=%0d bad=%0d", total, bad);
    test_rsp_stall();
    $display("test_rsp_stall done total=%0d bad=%0d", total, bad);
    test_short_burst();
    $display("test_short_burst done total=%0d bad=%0d", total, bad);
    test_async_reset();
    $display("test_async_reset done total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
